// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the square-root request scheduler.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int unsigned ERR_CNT_W = 8;

  // Requester id width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, modulo N_REQ.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  // Rotating priority search starting from ptr.
  always_comb begin
    logic              found;
    int unsigned       cand;
    logic [ID_W-1:0]   cand_id;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand    = (int'(ptr) + off) % N_REQ;
      cand_id = ID_W'(cand);
      if (en && !found && req[cand_id]) begin
        found        = 1'b1;
        gnt[cand_id] = 1'b1;
        gnt_idx      = cand_id;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one iterative square-root core among N_REQ requesters, round-robin,
// with a watchdog on the core and a single tagged response port.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RES_W       = DATA_W / 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned ID_W        = id_width(N_REQ)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    core_start,
  output logic [DATA_W-1:0]       core_operand,
  input  logic                    core_done,
  input  logic [RES_W-1:0]        core_result,
  output logic                    busy,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t          state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_W-1:0]     operand_q, operand_d;
  logic [RES_W-1:0]      rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [N_REQ-1:0]      gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_W-1:0]     op_sel;
  logic [WD_W-1:0]       wd_inc;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // State and datapath registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      operand_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_q       <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      operand_q  <= operand_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state, pointer, watchdog and response-register updates.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    operand_d  = operand_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
    err_cnt_d  = err_cnt_q;
    wd_inc     = wd_q + 1'b1;
    op_sel     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      op_sel = op_sel | (req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
    end
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          operand_d = op_sel;
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_inc;
        // done takes priority over a watchdog expiry in the same cycle
        if (core_done) begin
          rsp_data_d = core_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_inc == WD_W'(TIMEOUT_CYC)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    req_ready    = gnt;
    core_start   = (state_q == ISSUE);
    rsp_valid    = (state_q == RESP);
    busy         = (state_q != IDLE);
    rsp_id       = id_q;
    rsp_data     = rsp_data_q;
    rsp_err      = rsp_err_q;
    core_operand = operand_q;
    err_cnt      = err_cnt_q;
  end

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed, table-driven bench for sqrt_sched with a behavioural sqrt core.
module tb_sqrt_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 16;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_data;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err, core_start;
  logic [DW-1:0]   core_operand;
  logic            core_done;
  logic [RW-1:0]   core_result;
  logic            busy;
  logic [7:0]      err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int core_lat = 16;
  bit core_en = 1'b1;

  always #5 ACLK = ~ACLK;

  sqrt_sched #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .RES_W       (RW),
    .TIMEOUT_CYC (64)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .core_start   (core_start),
    .core_operand (core_operand),
    .core_done    (core_done),
    .core_result  (core_result),
    .busy         (busy),
    .err_cnt      (err_cnt)
  );

  typedef struct {
    logic [N-1:0]    mask;
    logic [N*DW-1:0] data;
    int              lat;
    bit              en;
    int              id;
    logic [RW-1:0]   res;
    bit              err;
    int              rsp_at;
    int              bp;
    logic [7:0]      ecnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] x);
    longint unsigned r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return RW'(r);
  endfunction

  function automatic vec_t mk(input logic [N-1:0] mask, input logic [N*DW-1:0] data,
                              input int lat, input bit en, input int id,
                              input logic [RW-1:0] res, input bit err, input int rsp_at,
                              input int bp, input logic [7:0] ecnt);
    vec_t v;
    v.mask = mask; v.data = data; v.lat = lat; v.en = en; v.id = id;
    v.res = res; v.err = err; v.rsp_at = rsp_at; v.bp = bp; v.ecnt = ecnt;
    return v;
  endfunction

  // Behavioural core: answers k cycles after the start cycle unless disabled.
  initial begin
    logic [RW-1:0] r;
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge ACLK);
      if (core_start === 1'b1 && core_en) begin
        r = isqrt(core_operand);
        repeat (core_lat) @(negedge ACLK);
        core_done   = 1'b1;
        core_result = r;
        @(negedge ACLK);
        core_done   = 1'b0;
        core_result = '0;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_operand"}, core_operand, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // One full transaction; called at a negedge, returns at the negedge after the response handshake.
  task automatic txn(input vec_t v);
    int n;
    logic [RW+2:0] held;
    core_lat  = v.lat;
    core_en   = v.en;
    req_data  = v.data;
    req_valid = v.mask;
    rsp_ready = 1'b0;
    #1;
    chk("grant", req_ready, 64'(1) << v.id);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("core_start", core_start, 1);
    chk("core_operand", core_operand, v.data[v.id*DW +: DW]);
    chk("busy", busy, 1);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("rsp_latency", n, v.rsp_at);
    chk("rsp_id", rsp_id, v.id);
    chk("rsp_data", rsp_data, v.res);
    chk("rsp_err", rsp_err, v.err);
    chk("err_cnt", err_cnt, v.ecnt);
    held = {rsp_id, rsp_data, rsp_err};
    for (int i = 0; i < v.bp; i++) begin
      @(negedge ACLK);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, held});
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("idle_after_rsp", busy, 0);
    rsp_ready = 1'b0;
    req_valid = '0;
  endtask

  localparam logic [N*DW-1:0] D_FAIR   = {32'd16, 32'd9, 32'd4, 32'd1};
  localparam logic [N*DW-1:0] D_SINGLE = {96'd0, 32'h10};
  localparam logic [N*DW-1:0] D_BP     = {32'd0, 32'h100, 64'd0};
  localparam logic [N*DW-1:0] D_PAIR   = {32'd100, 32'd0, 32'd81, 32'd0};
  localparam logic [N*DW-1:0] D_SIM    = {32'd0, 32'd144, 64'd0};
  localparam logic [N*DW-1:0] D_63     = {32'd225, 96'd0};
  localparam logic [N*DW-1:0] D_RST    = {64'd0, 32'd36, 32'd0};
  localparam logic [N*DW-1:0] D_POST   = {32'd0, 32'd49, 32'd0, 32'd25};

  initial begin
    vec_t tv[13];
    int   seen;
    //             mask     data      lat en id res    err at  bp ecnt
    tv[0]  = mk(4'b1111, D_FAIR,   16, 1, 0, 16'd1,  0, 18, 0, 8'd0);
    tv[1]  = mk(4'b1111, D_FAIR,   16, 1, 1, 16'd2,  0, 18, 0, 8'd0);
    tv[2]  = mk(4'b1111, D_FAIR,   16, 1, 2, 16'd3,  0, 18, 0, 8'd0);
    tv[3]  = mk(4'b1111, D_FAIR,   16, 1, 3, 16'd4,  0, 18, 0, 8'd0);
    tv[4]  = mk(4'b1111, D_FAIR,   16, 1, 0, 16'd1,  0, 18, 0, 8'd0);
    tv[5]  = mk(4'b0001, D_SINGLE, 16, 1, 0, 16'd4,  0, 18, 0, 8'd0);
    tv[6]  = mk(4'b0100, D_BP,     16, 1, 2, 16'h10, 0, 18, 5, 8'd0);
    tv[7]  = mk(4'b1010, D_PAIR,    1, 1, 3, 16'd10, 0,  3, 0, 8'd0);
    tv[8]  = mk(4'b1010, D_PAIR,   16, 1, 1, 16'd9,  0, 18, 0, 8'd0);
    tv[9]  = mk(4'b0001, D_SINGLE, 16, 0, 0, 16'd0,  1, 66, 0, 8'd1);
    tv[10] = mk(4'b0001, D_SINGLE, 16, 1, 0, 16'd4,  0, 18, 0, 8'd1);
    tv[11] = mk(4'b0100, D_SIM,    64, 1, 2, 16'd12, 0, 66, 0, 8'd1);
    tv[12] = mk(4'b1000, D_63,     63, 1, 3, 16'd15, 0, 65, 0, 8'd1);

    ARESET    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_zero("reset");
    ARESET = 1'b0;
    @(negedge ACLK);

    for (int i = 0; i < 13; i++) txn(tv[i]);

    // Abort in WAIT: requester 1 accepted (pointer moves to 2), then reset.
    core_lat  = 16;
    core_en   = 1'b1;
    req_data  = D_RST;
    req_valid = 4'b0010;
    #1;
    chk("rst_grant", req_ready, 4'b0010);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_core_start", core_start, 1);
    req_valid = '0;
    repeat (3) @(negedge ACLK);
    #2 ARESET = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge ACLK);
    ARESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("late_done_dropped", seen, 0);
    // Pointer restarts at 0, so requester 0 wins over requester 2.
    txn(mk(4'b0101, D_POST, 16, 1, 0, 16'd5, 0, 18, 0, 8'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sqrt_sched.md
# sqrt_sched

Round-robin scheduler that shares one iterative square-root core among `N_REQ` requesters. It sits between the requesters' valid/ready command ports and the shared core's start/done interface. It accepts one operand at a time, pulses the core's start, and waits for done under a watchdog. It then returns the result tagged with the requester id on a single valid/ready response port.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `DATA_W`, 32: operand width.
- `RES_W`, `DATA_W/2`: result width.
- `TIMEOUT_CYC`, 64: maximum number of WAIT cycles before abort.
- `ID_W`, `$clog2(N_REQ)`: width of the requester id.

Ports:
- `ACLK` in 1: clock, rising edge.
- `ARESET` in 1: reset, asynchronous, active-high.
- `req_valid` in `N_REQ`: per-requester command valid.
- `req_ready` out `N_REQ`: one-hot grant/accept.
- `req_data` in `N_REQ*DATA_W`: operands; requester i uses slice `[i*DATA_W +: DATA_W]`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out `ID_W`: id of the requester being answered.
- `rsp_data` out `RES_W`: square-root result; 0 on error.
- `rsp_err` out 1: watchdog timeout flag for this response.
- `core_start` out 1: single-cycle start pulse to the core.
- `core_operand` out `DATA_W`: latched operand, stable from start until done.
- `core_done` in 1: core completion pulse.
- `core_result` in `RES_W`: core result, valid with `core_done`.
- `busy` out 1: high whenever state ≠ IDLE.
- `err_cnt` out 8: saturating count of timeouts.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, the arbiter grants requester g, the first valid at or after `ptr` (searching modulo `N_REQ`).
  - `req_ready[g]` is high in that same cycle (combinational from `req_valid`, IDLE only).
  - On the handshake: latch the operand and id, set `ptr` ← (g+1) mod `N_REQ`, go to ISSUE.
- **ISSUE:** `core_start`=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- **WAIT:**
  - Each cycle: increment the watchdog counter.
  - If `core_done`=1: register `core_result` into `rsp_data`, `rsp_err`=0, go to RESP.
  - Else, if the counter reaches `TIMEOUT_CYC`: `rsp_data`=0, `rsp_err`=1, increment `err_cnt` (saturating at 255), go to RESP.
  - If `core_done` arrives in the same cycle the limit is hit, done wins: no error is flagged.
- **RESP:**
  - `rsp_valid`=1; `rsp_id`, `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On the handshake: go to IDLE.
- No new request is accepted outside IDLE; `req_ready` is all zero there.
- `core_done` is ignored in IDLE, ISSUE and RESP (a stale done is dropped).
- `core_operand` holds the latched value from ISSUE until the next acceptance.
- Reset mid-operation aborts the transaction. The core is not notified; a late `core_done` arrives in IDLE and is discarded.

## Timing
- Reset values: state IDLE, `ptr`=0, `err_cnt`=0. `req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `core_start`, `core_operand`, `busy` all 0.
- Request accepted in cycle T:
  - `core_start` is high in T+1.
  - Core done in cycle T+1+k → `rsp_valid` rises in T+2+k.
- Timeout: `rsp_valid` rises in T+2+`TIMEOUT_CYC`.
- Response handshake in cycle R → next acceptance possible in R+1 (one response in flight at most).
- Throughput: one operation per (k+3) cycles minimum with `rsp_ready` tied high.

## Structure
- Package `sqrt_sched_pkg`:
  - state enum `sched_state_t` (IDLE, ISSUE, WAIT, RESP);
  - `ERR_CNT_W`=8;
  - helper function computing `ID_W`.
- Sub-module `rr_arbiter`:
  - parameter `N_REQ`;
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded index.
- Pointer update, FSM, watchdog and response registers live in `sqrt_sched`.

## Test plan
Core model has fixed latency k=16 unless stated.
- **Single request:** `req_valid[0]`=1 with operand 0x00000010 → `core_start` at T+1, `core_operand`=0x10. Response at T+18 with id 0, data 0x0004, err 0.
- **Fairness:** all four valid continuously with operands 1, 4, 9, 16 → grant order 0,1,2,3,0. Responses carry data 1, 2, 3, 4 with matching ids.
- **Backpressure:** `rsp_ready` held low 5 cycles after `rsp_valid` → id, data and err stable. `req_ready`=0 throughout; acceptance in the cycle after the handshake.
- **Timeout:** core never asserts done, `TIMEOUT_CYC`=64 → `rsp_valid` at T+66 with `rsp_err`=1, data 0, `err_cnt`=1. A subsequent normal request succeeds.
- **Simultaneity:** `core_done` asserted in the 64th WAIT cycle → result returned, `rsp_err`=0, `err_cnt` unchanged.
- **Reset in WAIT:** `ARESET` pulsed 3 cycles after start → all outputs 0 immediately. Late `core_done` is ignored and no response is produced. The next request is granted starting from `ptr`=0.
